// File: rtl/byte_ram.sv
// byte_ram: single-port, byte-addressed synchronous RAM with a multi-byte word
// interface, per-byte write enables and a valid/ready request handshake.
// After reset a self-clear pass zeroes the whole array before requests are
// accepted. Read data is registered and comes back with a one-cycle strobe.
//
// Parameters
//   ADDR_WIDTH  byte-address width, array depth LENGTH = 1<<ADDR_WIDTH bytes
//   WORD_BYTES  bytes per access (power of two, 1..LENGTH)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only after the clear pass)
//   req_we            1 = write, 0 = read
//   req_addr          byte address of lane 0, any alignment, wraps mod LENGTH
//   req_be            per-lane write enable (ignored on reads)
//   req_wdata         write data, lane i = bits [8i+7:8i]
//   err_inject        store inverted parity on write (parity build only)
//   rsp_valid         one-cycle read strobe
//   rsp_rdata         read data, held between strobes
//   rsp_err           parity mismatch on any lane of this response
//   init_done         clear pass complete
//
// Build option
//   BYTE_RAM_PARITY_EN  adds a 9th even-parity bit per byte; without it
//                       err_inject is ignored and rsp_err is tied to 0.

module byte_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int WORD_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [WORD_BYTES-1:0]   req_be,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  input  logic                    err_inject,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_done
);

  localparam int LENGTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(LENGTH - WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] CLR_STEP = ADDR_WIDTH'(WORD_BYTES);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                          state_q;
  logic [ADDR_WIDTH-1:0]           clr_cnt_q;
  logic                            ready_q, done_q;
  logic                            rsp_valid_q, rsp_err_q;
  logic [8*WORD_BYTES-1:0]         rsp_rdata_q;

  logic [7:0]                      mem [LENGTH];

  logic                            clearing, accept, rd_acc;
  logic [WORD_BYTES-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [WORD_BYTES-1:0]           lane_wen;
  logic [WORD_BYTES-1:0][7:0]      lane_wdata;
  logic [WORD_BYTES-1:0][7:0]      rd_byte;
  logic [8*WORD_BYTES-1:0]         rsp_rdata_d;
  logic                            rsp_err_d;

  assign clearing = (state_q == ST_CLEAR);
  assign accept   = req_valid & ready_q;
  assign rd_acc   = accept & ~req_we;

  // The clear pass reuses the lane datapath: aligned counter address,
  // all lanes enabled, zero data.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    assign lane_addr[gi]  = (clearing ? clr_cnt_q : req_addr) + ADDR_WIDTH'(gi);
    assign lane_wen[gi]   = clearing | (accept & req_we & req_be[gi]);
    assign lane_wdata[gi] = clearing ? 8'h00 : req_wdata[8*gi +: 8];
    assign rd_byte[gi]    = mem[lane_addr[gi]];
  end

  assign rsp_rdata_d = rd_byte;

  // Storage has no reset; only the clear pass defines its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++)
      if (lane_wen[i]) mem[lane_addr[i]] <= lane_wdata[i];
  end

`ifdef BYTE_RAM_PARITY_EN
  logic                  mem_par [LENGTH];
  logic [WORD_BYTES-1:0] lane_par, lane_perr;

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_par
    // Even parity: stored bit equals XOR of the data bits.
    assign lane_par[gi]  = clearing ? 1'b0 : (^lane_wdata[gi]) ^ err_inject;
    assign lane_perr[gi] = (^rd_byte[gi]) ^ mem_par[lane_addr[gi]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++)
      if (lane_wen[i]) mem_par[lane_addr[i]] <= lane_par[i];
  end

  assign rsp_err_d = |lane_perr;
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign rsp_err_d         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + CLR_STEP;
          if (clr_cnt_q == CLR_LAST) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
      rsp_valid_q <= rd_acc;
      if (rd_acc) begin
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= rsp_err_d;
      end
    end
  end

  assign req_ready = ready_q;
  assign init_done = done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_byte_ram.sv
// Bench for byte_ram at ADDR_WIDTH=4, WORD_BYTES=2. A byte-level model
// predicts read data/parity; reads push expectations with their due cycle,
// a negedge monitor pops and compares them as strobes arrive.

module tb_byte_ram;

  localparam int AW = 4;
  localparam int WB = 2;
  localparam int LEN = 1 << AW;
`ifdef BYTE_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0, req_we = 1'b0, err_inject = 1'b0;
  logic            req_ready, rsp_valid, rsp_err, init_done;
  logic [AW-1:0]   req_addr = '0;
  logic [WB-1:0]   req_be = '0;
  logic [8*WB-1:0] req_wdata = '0, rsp_rdata;

  byte_ram #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .err_inject(err_inject),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] m_mem [LEN];
  logic       m_bad [LEN];

  function automatic void model_clear();
    for (int i = 0; i < LEN; i++) begin
      m_mem[i] = 8'h00;
      m_bad[i] = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rdata", rsp_rdata, mon_e.data);
        chk("rsp_err", rsp_err, mon_e.err);
        chk("latency", cyc, mon_e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("missing_rsp", 0, 1);
      void'(sb.pop_front());
    end
  end

  // Issue one request in IDLE; it is accepted at the next rising edge.
  task automatic req(input bit we, input logic [AW-1:0] a, input logic [WB-1:0] be,
                     input logic [15:0] wd, input bit inj);
    exp_t e;
    logic [AW-1:0] la;
    req_valid = 1'b1; req_we = we; req_addr = a; req_be = be;
    req_wdata = wd; err_inject = inj;
    @(posedge clk); #1;
    if (we) begin
      for (int i = 0; i < WB; i++) if (be[i]) begin
        la = a + AW'(i);
        m_mem[la] = wd[8*i +: 8];
        m_bad[la] = inj;
      end
    end else begin
      e.data = '0; e.err = 1'b0; e.due = cyc;
      for (int i = 0; i < WB; i++) begin
        la = a + AW'(i);
        e.data[8*i +: 8] = m_mem[la];
        e.err = e.err | (PAR & m_bad[la]);
      end
      sb.push_back(e);
    end
    req_valid = 1'b0; err_inject = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (init_done) break;
    end
    chk(tag, n, LEN / WB);
    chk({tag, "_ready"}, req_ready, 1);
    model_clear();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_done"}, init_done, 0);
    chk({tag, "_vld"}, rsp_valid, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_err"}, rsp_err, 0);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");

    // Clear pass after first release; all bytes must read zero.
    @(negedge clk); rst_n = 1'b1;
    wait_init("init_edges");
    for (int a = 0; a < LEN; a++) req(1'b0, AW'(a), '0, '0, 1'b0);
    drain();

    // Byte enables
    req(1'b1, 4'd6, 2'b11, 16'hBEEF, 1'b0);
    req(1'b1, 4'd6, 2'b10, 16'h12AB, 1'b0);
    req(1'b0, 4'd6, '0, '0, 1'b0);
    req(1'b0, 4'd7, '0, '0, 1'b0);
    drain();

    // Wrap at the top of the array
    req(1'b1, 4'd15, 2'b11, 16'hA55A, 1'b0);
    req(1'b0, 4'd0, '0, '0, 1'b0);
    req(1'b0, 4'd15, '0, '0, 1'b0);
    drain();

    // Write followed by back-to-back reads; the read right after the write
    // must see the new data.
    req(1'b1, 4'd2, 2'b11, 16'h1234, 1'b0);
    req(1'b0, 4'd2, '0, '0, 1'b0);
    req(1'b0, 4'd3, '0, '0, 1'b0);
    drain();
    @(negedge clk);
    chk("hold_vld", rsp_valid, 0);
    chk("hold_rdata", rsp_rdata, 16'h0012);

    // Parity injection and repair, plus a single-lane injection
    req(1'b1, 4'd4, 2'b11, 16'h00FF, 1'b1);
    req(1'b0, 4'd4, '0, '0, 1'b0);
    req(1'b1, 4'd4, 2'b11, 16'h00FF, 1'b0);
    req(1'b0, 4'd4, '0, '0, 1'b0);
    req(1'b1, 4'd9, 2'b10, 16'h7700, 1'b1);
    req(1'b0, 4'd8, '0, '0, 1'b0);
    req(1'b0, 4'd10, '0, '0, 1'b0);
    drain();

    // Random mix against the model
    for (int k = 0; k < 60; k++)
      req(1'($urandom_range(0, 1)), AW'($urandom_range(0, LEN - 1)),
          WB'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)));
    drain();

    // Reset while a response is on the bus: it is dropped at once.
    req(1'b0, 4'd6, '0, '0, 1'b0);
    chk("pre_rst_vld", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk_reset_outs("async_rst");
    @(negedge clk); rst_n = 1'b1;

    // Interrupt the clear pass at cycle 5 and restart it.
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midclr_rst");
    @(negedge clk); rst_n = 1'b1;
    // Requests during clear must be ignored (byte 0 is already cleared early
    // in the pass, so an accepted write would survive).
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_be = 2'b11;
    req_wdata = 16'hFFFF;
    wait_init("reinit_edges");
    req_valid = 1'b0;
    for (int a = 0; a < LEN; a++) req(1'b0, AW'(a), '0, '0, 1'b0);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
